truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Parametrised, synthesizable successor to our hand-written exhaustive input sweeps for small combinational blocks.
- Steps an N-bit input vector through all 2^N values and holds each for HOLD cycles.
- Samples the DUT's 1-bit output at the end of each hold window and checks it against a truth-table parameter.
- Reports mismatch count, first failing vector and pass/fail. Used in benches and on-board self-test wrappers for our ep-series logic blocks.

Parameters:
- N, 4, DUT input width in bits; legal range 1..8.
- HOLD, 20, cycles each vector is held; legal range HOLD >= 2.
- EXPECT, 16'hB2F0, 2^N-bit truth table; bit index i is the expected dut_out for vec == i.
- STOP_ON_FAIL, 0, when 1 the sweep ends right after the first mismatch.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle run request; honoured only in IDLE or DONE.
- dut_out  in  1  DUT output driven by the current vec.
- vec  out  N  current stimulus vector, connected to the DUT inputs.
- vec_valid  out  1  high while vec is being applied (APPLY state).
- busy  out  1  high from start acceptance until the sweep ends.
- done  out  1  high in DONE; held until the next start or rst.
- pass  out  1  valid when done=1; equals (err_count == 0).
- err_count  out  N+1  number of mismatching vectors; max 2^N, so it never saturates.
- first_fail  out  N  vector of the first mismatch.
- first_fail_valid  out  1  high once any mismatch has been recorded.

Behaviour:
- Reset values: all outputs 0. The FSM goes to IDLE and hold_cnt goes to 0.
- rst has priority over every other input. Asserting rst mid-sweep returns all outputs to reset values at that edge, with no partial results kept.
- States:
  - IDLE: outputs at reset values. start=1 moves the FSM to APPLY.
  - APPLY: vec is applied. hold_cnt counts 0..HOLD-1.
  - DONE: done=1, busy=0, vec_valid=0. Results are frozen.
- Start acceptance, from IDLE or DONE at edge t0:
  - next state APPLY; vec=0, hold_cnt=0.
  - err_count, first_fail and first_fail_valid cleared.
  - done=0, pass=0; busy=1 and vec_valid=1 from t0 onward.
- start is ignored while in APPLY.
- Hold window: each vec is held for exactly HOLD cycles. At the edge where hold_cnt == HOLD-1, dut_out is compared with EXPECT[vec].
- On a mismatch:
  - err_count increments.
  - If first_fail_valid=0, first_fail is set to vec and first_fail_valid to 1 at the same edge.
- End of window, no stop:
  - If vec == 2^N-1, go to DONE.
  - Otherwise vec increments by 1 and hold_cnt returns to 0.
- STOP_ON_FAIL=1 and a mismatch at the sample edge: go to DONE at that edge. vec keeps the failing value in DONE; vec_valid=0.
- Latency:
  - Full sweep: done rises 2^N*HOLD edges after t0. With N=4 and HOLD=20 that is 320.
  - Early stop on vector k: 2^N*HOLD becomes (k+1)*HOLD.
- In DONE, pass = (err_count == 0). Outputs are stable until start or rst.
- vec never wraps past 2^N-1. The last vector is always sampled before DONE.
- N=1 degenerate case: two vectors; behaviour otherwise identical.

Test Plan:
- Reset: hold rst 3 cycles with start=1 -> all outputs 0, FSM stays IDLE (start ignored under rst).
- Golden DUT model (dut_out = EXPECT[vec]), N=4, HOLD=20, EXPECT=16'hB2F0; pulse start:
  - vec = 0..15, each for 20 cycles; done=1 at t0+320.
  - pass=1, err_count=0, first_fail_valid=0.
  - Re-pulse start in APPLY -> no effect.
- Faulty DUT, output inverted for vec 5 and 9 -> done at t0+320, err_count=2, first_fail=5, first_fail_valid=1, pass=0.
- STOP_ON_FAIL=1, inverted at vec 5 -> done at t0+120, vec=5, err_count=1, first_fail=5; vec 6 never applied.
- Reset mid-run: rst one cycle while vec=7 -> next edge all outputs 0, FSM in IDLE. Then start from DONE after a failing run clears err_count and first_fail_valid on acceptance.
- N=2, HOLD=2, EXPECT=4'b0110 with XOR DUT -> vec 0,1,2,3 two cycles each, done at t0+8, pass=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks an N-bit vector through all 2^N values,
// samples a 1-bit DUT response at the end of each hold window and tallies mismatches.
module truth_table_sweeper #(
    parameter int                 N            = 4,
    parameter int                 HOLD         = 20,
    parameter logic [(1<<N)-1:0]  EXPECT       = 16'hB2F0,
    parameter bit                 STOP_ON_FAIL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dut_out,
    output logic [N-1:0]  vec,
    output logic          vec_valid,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [N:0]    err_count,
    output logic [N-1:0]  first_fail,
    output logic          first_fail_valid
);

    localparam int             HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD - 1);
    localparam logic [HW-1:0]  HOLD_ONE  = HW'(1);
    localparam logic [N-1:0]   VEC_LAST  = {N{1'b1}};
    localparam logic [N-1:0]   VEC_ONE   = N'(1);
    localparam logic [N:0]     ERR_ONE   = (N+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   vec_reg, vec_next;
    logic [HW-1:0]  hold_cnt_reg, hold_cnt_next;
    logic [N:0]     err_count_reg, err_count_next;
    logic [N-1:0]   first_fail_reg, first_fail_next;
    logic           first_fail_valid_reg, first_fail_valid_next;

    logic           sample_edge;
    logic           mismatch;

    assign sample_edge = (state_reg == ST_APPLY) && (hold_cnt_reg == HOLD_LAST);
    assign mismatch    = sample_edge && (dut_out != EXPECT[vec_reg]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg            <= ST_IDLE;
            vec_reg              <= '0;
            hold_cnt_reg         <= '0;
            err_count_reg        <= '0;
            first_fail_reg       <= '0;
            first_fail_valid_reg <= 1'b0;
        end else begin
            state_reg            <= state_next;
            vec_reg              <= vec_next;
            hold_cnt_reg         <= hold_cnt_next;
            err_count_reg        <= err_count_next;
            first_fail_reg       <= first_fail_next;
            first_fail_valid_reg <= first_fail_valid_next;
        end
    end

    always_comb begin
        state_next            = state_reg;
        vec_next              = vec_reg;
        hold_cnt_next         = hold_cnt_reg;
        err_count_next        = err_count_reg;
        first_fail_next       = first_fail_reg;
        first_fail_valid_next = first_fail_valid_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                // A new run wipes every result from the previous one.
                if (start) begin
                    state_next            = ST_APPLY;
                    vec_next              = '0;
                    hold_cnt_next         = '0;
                    err_count_next        = '0;
                    first_fail_next       = '0;
                    first_fail_valid_next = 1'b0;
                end
            end
            ST_APPLY: begin
                if (sample_edge) begin
                    if (mismatch) begin
                        err_count_next = err_count_reg + ERR_ONE;
                        if (!first_fail_valid_reg) begin
                            first_fail_next       = vec_reg;
                            first_fail_valid_next = 1'b1;
                        end
                    end
                    // Early stop leaves vec parked on the failing vector.
                    if ((mismatch && STOP_ON_FAIL) || (vec_reg == VEC_LAST)) begin
                        state_next = ST_DONE;
                    end else begin
                        vec_next      = vec_reg + VEC_ONE;
                        hold_cnt_next = '0;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign vec              = vec_reg;
    assign vec_valid        = (state_reg == ST_APPLY);
    assign busy             = (state_reg == ST_APPLY);
    assign done             = (state_reg == ST_DONE);
    assign pass             = (state_reg == ST_DONE) && (err_count_reg == '0);
    assign err_count        = err_count_reg;
    assign first_fail       = first_fail_reg;
    assign first_fail_valid = first_fail_valid_reg;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: golden, faulty, early-stop, restart,
// mid-run reset and a small N=2 XOR sweep, each with hand-computed expectations.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Instance A: N=4, HOLD=20, full sweep
    logic        rst_a, start_a, dut_out_a;
    logic [3:0]  vec_a, first_fail_a;
    logic        vec_valid_a, busy_a, done_a, pass_a, first_fail_valid_a;
    logic [4:0]  err_count_a;

    // Instance B: N=4, HOLD=20, stop on first failure
    logic        rst_b, start_b, dut_out_b;
    logic [3:0]  vec_b, first_fail_b;
    logic        vec_valid_b, busy_b, done_b, pass_b, first_fail_valid_b;
    logic [4:0]  err_count_b;

    // Instance C: N=2, HOLD=2, XOR truth table
    logic        rst_c, start_c, dut_out_c;
    logic [1:0]  vec_c, first_fail_c;
    logic        vec_valid_c, busy_c, done_c, pass_c, first_fail_valid_c;
    logic [2:0]  err_count_c;

    logic [15:0] exp_tab = 16'hB2F0;
    logic [15:0] fault_a = 16'h0000;
    logic [15:0] fault_b = 16'h0000;

    assign dut_out_a = exp_tab[vec_a] ^ fault_a[vec_a];
    assign dut_out_b = exp_tab[vec_b] ^ fault_b[vec_b];
    assign dut_out_c = vec_c[0] ^ vec_c[1];

    truth_table_sweeper #(.N(4), .HOLD(20), .EXPECT(16'hB2F0), .STOP_ON_FAIL(1'b0)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .dut_out(dut_out_a),
        .vec(vec_a), .vec_valid(vec_valid_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_count_a), .first_fail(first_fail_a), .first_fail_valid(first_fail_valid_a)
    );

    truth_table_sweeper #(.N(4), .HOLD(20), .EXPECT(16'hB2F0), .STOP_ON_FAIL(1'b1)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .dut_out(dut_out_b),
        .vec(vec_b), .vec_valid(vec_valid_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_count_b), .first_fail(first_fail_b), .first_fail_valid(first_fail_valid_b)
    );

    truth_table_sweeper #(.N(2), .HOLD(2), .EXPECT(4'b0110), .STOP_ON_FAIL(1'b0)) u_dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .dut_out(dut_out_c),
        .vec(vec_c), .vec_valid(vec_valid_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_count_c), .first_fail(first_fail_c), .first_fail_valid(first_fail_valid_c)
    );

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if ({vec_a, vec_valid_a, busy_a, done_a, pass_a, err_count_a, first_fail_a, first_fail_valid_a} !== 18'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_a cycle %0d: vec=%0d busy=%b done=%b err=%0d ffv=%b, required all zero",
                         i, vec_a, busy_a, done_a, err_count_a, first_fail_valid_a);
            end
            tests_run++;
            if ({vec_b, vec_valid_b, busy_b, done_b, pass_b, err_count_b, first_fail_b, first_fail_valid_b} !== 18'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_b cycle %0d: vec=%0d busy=%b done=%b, required all zero", i, vec_b, busy_b, done_b);
            end
            tests_run++;
            if ({vec_c, vec_valid_c, busy_c, done_c, pass_c, err_count_c, first_fail_c, first_fail_valid_c} !== 12'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_c cycle %0d: vec=%0d busy=%b done=%b, required all zero", i, vec_c, busy_c, done_c);
            end
        end
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({busy_a, busy_b, busy_c, done_a, done_b, done_c} !== 6'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: busy=%b%b%b done=%b%b%b, required 000 000",
                     busy_a, busy_b, busy_c, done_a, done_b, done_c);
        end
        $display("[TB] reset: 3 cycles with start held, sweepers idle");
    endtask

    task automatic test_golden();
        fault_a = 16'h0000;
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        tests_run++;
        if (busy_a !== 1'b1 || vec_valid_a !== 1'b1 || vec_a !== 4'd0 || done_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL golden_t0: busy=%b vv=%b vec=%0d done=%b, required 1 1 0 0", busy_a, vec_valid_a, vec_a, done_a);
        end
        for (int cyc = 1; cyc <= 320; cyc++) begin
            start_a = (cyc == 100);
            @(posedge clk); #1;
            if (cyc < 320) begin
                tests_run++;
                if (vec_a !== 4'(cyc / 20) || done_a !== 1'b0 || busy_a !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL golden_seq t0+%0d: vec=%0d done=%b busy=%b, required vec=%0d done=0 busy=1",
                             cyc, vec_a, done_a, busy_a, cyc / 20);
                end
            end
        end
        start_a = 1'b0;
        tests_run++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || vec_valid_a !== 1'b0 || pass_a !== 1'b1 ||
            err_count_a !== 5'd0 || first_fail_valid_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL golden_done t0+320: done=%b busy=%b vv=%b pass=%b err=%0d ffv=%b, required 1 0 0 1 0 0",
                     done_a, busy_a, vec_valid_a, pass_a, err_count_a, first_fail_valid_a);
        end
        $display("[TB] golden: 16 vectors x 20 cycles, done at t0+320, pass=%b err=%0d", pass_a, err_count_a);
    endtask

    task automatic test_faulty();
        fault_a = 16'h0220;
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        for (int cyc = 1; cyc <= 320; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 119) begin
                tests_run++;
                if (first_fail_valid_a !== 1'b0 || err_count_a !== 5'd0) begin
                    tests_failed++;
                    $display("[TB] FAIL faulty_pre5: ffv=%b err=%0d, required 0 0", first_fail_valid_a, err_count_a);
                end
            end
            if (cyc == 120) begin
                tests_run++;
                if (first_fail_valid_a !== 1'b1 || first_fail_a !== 4'd5 || err_count_a !== 5'd1) begin
                    tests_failed++;
                    $display("[TB] FAIL faulty_at5: ffv=%b ff=%0d err=%0d, required 1 5 1",
                             first_fail_valid_a, first_fail_a, err_count_a);
                end
            end
            if (cyc == 200) begin
                tests_run++;
                if (err_count_a !== 5'd2 || first_fail_a !== 4'd5) begin
                    tests_failed++;
                    $display("[TB] FAIL faulty_at9: err=%0d ff=%0d, required 2 5", err_count_a, first_fail_a);
                end
            end
            if (cyc == 319) begin
                tests_run++;
                if (done_a !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL faulty_early_done t0+319: done=%b, required 0", done_a);
                end
            end
        end
        tests_run++;
        if (done_a !== 1'b1 || pass_a !== 1'b0 || err_count_a !== 5'd2 || first_fail_a !== 4'd5 ||
            first_fail_valid_a !== 1'b1 || vec_a !== 4'd15 || vec_valid_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL faulty_done: done=%b pass=%b err=%0d ff=%0d ffv=%b vec=%0d vv=%b, required 1 0 2 5 1 15 0",
                     done_a, pass_a, err_count_a, first_fail_a, first_fail_valid_a, vec_a, vec_valid_a);
        end
        $display("[TB] faulty: inverted at 5 and 9, err=%0d first_fail=%0d pass=%b", err_count_a, first_fail_a, pass_a);
    endtask

    task automatic test_restart_and_midrun_reset();
        // instance A sits in DONE with two recorded failures
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        tests_run++;
        if (err_count_a !== 5'd0 || first_fail_valid_a !== 1'b0 || first_fail_a !== 4'd0 ||
            done_a !== 1'b0 || pass_a !== 1'b0 || busy_a !== 1'b1 || vec_a !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL restart_clear: err=%0d ffv=%b ff=%0d done=%b pass=%b busy=%b vec=%0d, required 0 0 0 0 0 1 0",
                     err_count_a, first_fail_valid_a, first_fail_a, done_a, pass_a, busy_a, vec_a);
        end
        repeat (145) @(posedge clk);
        #1;
        tests_run++;
        if (vec_a !== 4'd7 || err_count_a !== 5'd1) begin
            tests_failed++;
            $display("[TB] FAIL midrun_pre: vec=%0d err=%0d, required 7 1", vec_a, err_count_a);
        end
        rst_a = 1'b1;
        @(posedge clk); #1; rst_a = 1'b0;
        tests_run++;
        if ({vec_a, vec_valid_a, busy_a, done_a, pass_a, err_count_a, first_fail_a, first_fail_valid_a} !== 18'd0) begin
            tests_failed++;
            $display("[TB] FAIL midrun_reset: vec=%0d busy=%b done=%b err=%0d ffv=%b, required all zero",
                     vec_a, busy_a, done_a, err_count_a, first_fail_valid_a);
        end
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (busy_a !== 1'b0 || vec_a !== 4'd0 || done_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrun_idle: busy=%b vec=%0d done=%b, required 0 0 0", busy_a, vec_a, done_a);
        end
        $display("[TB] restart from DONE cleared results; reset at vec 7 returned to idle");
    endtask

    task automatic test_stop_on_fail();
        fault_b = 16'h0020;
        @(negedge clk); start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        for (int cyc = 1; cyc < 120; cyc++) begin
            @(posedge clk); #1;
            tests_run++;
            if (vec_b !== 4'(cyc / 20) || done_b !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL stop_seq t0+%0d: vec=%0d done=%b, required vec=%0d done=0", cyc, vec_b, done_b, cyc / 20);
            end
        end
        @(posedge clk); #1;
        tests_run++;
        if (done_b !== 1'b1 || vec_b !== 4'd5 || vec_valid_b !== 1'b0 || busy_b !== 1'b0 || err_count_b !== 5'd1 ||
            first_fail_b !== 4'd5 || first_fail_valid_b !== 1'b1 || pass_b !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stop_done t0+120: done=%b vec=%0d vv=%b busy=%b err=%0d ff=%0d ffv=%b pass=%b, required 1 5 0 0 1 5 1 0",
                     done_b, vec_b, vec_valid_b, busy_b, err_count_b, first_fail_b, first_fail_valid_b, pass_b);
        end
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            tests_run++;
            if (vec_b !== 4'd5 || done_b !== 1'b1 || err_count_b !== 5'd1) begin
                tests_failed++;
                $display("[TB] FAIL stop_frozen +%0d: vec=%0d done=%b err=%0d, required 5 1 1", cyc, vec_b, done_b, err_count_b);
            end
        end
        $display("[TB] stop_on_fail: stopped at vec=%0d err=%0d", vec_b, err_count_b);
    endtask

    task automatic test_n2_xor();
        @(negedge clk); start_c = 1'b1;
        @(posedge clk); #1; start_c = 1'b0;
        tests_run++;
        if (vec_c !== 2'd0 || busy_c !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL n2_t0: vec=%0d busy=%b, required 0 1", vec_c, busy_c);
        end
        for (int cyc = 1; cyc < 8; cyc++) begin
            @(posedge clk); #1;
            tests_run++;
            if (vec_c !== 2'(cyc / 2) || done_c !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL n2_seq t0+%0d: vec=%0d done=%b, required vec=%0d done=0", cyc, vec_c, done_c, cyc / 2);
            end
        end
        @(posedge clk); #1;
        tests_run++;
        if (done_c !== 1'b1 || pass_c !== 1'b1 || err_count_c !== 3'd0 || vec_c !== 2'd3 || first_fail_valid_c !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL n2_done t0+8: done=%b pass=%b err=%0d vec=%0d ffv=%b, required 1 1 0 3 0",
                     done_c, pass_c, err_count_c, vec_c, first_fail_valid_c);
        end
        $display("[TB] n2_xor: 4 vectors x 2 cycles, done=%b pass=%b", done_c, pass_c);
    endtask

    initial begin
        test_reset();
        test_golden();
        test_faulty();
        test_restart_and_midrun_reset();
        test_stop_on_fail();
        test_n2_xor();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
